// File: rtl/counter_led_checker.sv
// Receive-side checker for the free-running 8-bit LED counter bus.
// Verifies +1 steps every DIV clocks; reports lock, errors and wraps.
module counter_led_checker #(
  parameter int DIV = 4,
  parameter int TOL = 0,
  parameter int GW  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  led_in,
  output logic        locked,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_cnt,
  output logic [15:0] wrap_cnt
);

  typedef enum logic [1:0] {
    ACQUIRE,
    ARM,
    TRACK
  } state_t;

  localparam logic [GW-1:0] GAP_LO  = GW'(DIV - TOL);
  localparam logic [GW-1:0] GAP_HI  = GW'(DIV + TOL);
  localparam logic [GW-1:0] GAP_MAX = '1;

  localparam logic [1:0] CODE_VALUE  = 2'd1;
  localparam logic [1:0] CODE_TIMING = 2'd2;
  localparam logic [1:0] CODE_STALL  = 2'd3;

  state_t        state;
  state_t        state_n;
  logic [7:0]    prev;
  logic [GW-1:0] gap;

  logic          change;
  logic          val_ok;
  logic          time_ok;
  logic          good;
  logic          stall;
  logic          det;
  logic [1:0]    code_n;
  logic          wrap_hit;

  assign change  = led_in != prev;
  assign val_ok  = led_in == prev + 8'd1;
  assign time_ok = (gap >= GAP_LO) && (gap <= GAP_HI);
  assign good    = val_ok && time_ok;
  // A change at the threshold cycle is judged on timing, never as a stall
  assign stall   = !change && (gap > GAP_HI);

  always_comb begin
    state_n  = state;
    det      = 1'b0;
    code_n   = err_code;
    wrap_hit = 1'b0;
    unique case (state)
      ACQUIRE: begin
        if (change)
          state_n = ARM;
      end
      ARM: begin
        if (change) begin
          if (good) begin
            state_n = TRACK;
          end else begin
            det    = 1'b1;
            code_n = val_ok ? CODE_TIMING : CODE_VALUE;
          end
        end else if (stall) begin
          det     = 1'b1;
          code_n  = CODE_STALL;
          state_n = ACQUIRE;
        end
      end
      TRACK: begin
        if (change) begin
          if (good) begin
            wrap_hit = prev == 8'hFF;
          end else begin
            det     = 1'b1;
            code_n  = val_ok ? CODE_TIMING : CODE_VALUE;
            state_n = ARM;
          end
        end else if (stall) begin
          det     = 1'b1;
          code_n  = CODE_STALL;
          state_n = ACQUIRE;
        end
      end
      default: begin
        state_n = ACQUIRE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACQUIRE;
      prev  <= 8'd0;
      gap   <= '0;
    end else begin
      state <= state_n;
      prev  <= led_in;
      if (change)
        gap <= GW'(1);
      else if (gap != GAP_MAX)
        gap <= gap + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked   <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      err_cnt  <= 8'd0;
      wrap_cnt <= 16'd0;
    end else begin
      locked   <= state_n == TRACK;
      err      <= det;
      err_code <= code_n;
      if (det && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (wrap_hit)
        wrap_cnt <= wrap_cnt + 16'd1;
    end
  end

endmodule
